// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine with a valid/ready handshake on both sides.
// Optional iteration counter output `cycles` is enabled by defining GCD_CYCLES_EN.
module gcd_stein #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef GCD_CYCLES_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  // k counts common factors of two; it can reach WIDTH-1.
  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_x, w_x_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             w_accept;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign w_accept  = in_valid && (r_state == IDLE);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_nxt  = r_state;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_k_nxt      = r_k;
    w_result_nxt = r_result;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_x_nxt = a;
          w_y_nxt = b;
          w_k_nxt = '0;
          if ((a == '0) || (b == '0)) begin
            w_result_nxt = a | b;
            w_state_nxt  = DONE;
          end else begin
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!r_x[0] && !r_y[0]) begin
          w_x_nxt = r_x >> 1;
          w_y_nxt = r_y >> 1;
          w_k_nxt = r_k + KW'(1);
        end else begin
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (!r_x[0])          w_x_nxt = r_x >> 1;
        else if (!r_y[0])     w_y_nxt = r_y >> 1;
        else if (r_x == r_y) begin
          w_result_nxt = r_x << r_k;
          w_state_nxt  = DONE;
        end
        else if (r_x > r_y)   w_x_nxt = r_x - r_y;
        else                  w_y_nxt = r_y - r_x;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_k      <= w_k_nxt;
      r_result <= w_result_nxt;
    end
  end

`ifdef GCD_CYCLES_EN
  logic [CNT_W-1:0] r_cnt;

  // Counts every SHIFT/CALC cycle, including the exit and equal cycles; saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (((r_state == SHIFT) || (r_state == CALC)) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cycles = r_cnt;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Directed testbench for gcd_stein: a 32-bit and an 8-bit instance share clock and reset.
// Cycle-count checks are compiled in only when GCD_CYCLES_EN is defined.
module tb_gcd_stein;

  logic        clk;
  logic        reset;

  logic        v32, rdy32, ov32, ordy32;
  logic [31:0] a32, b32, res32;
  logic [15:0] cyc32;

  logic        v8, rdy8, ov8, ordy8;
  logic [7:0]  a8, b8, res8;
  logic [15:0] cyc8;

  int n_vec;
  int n_err;

  gcd_stein #(.WIDTH(32), .CNT_W(16)) dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v32),
    .in_ready  (rdy32),
    .a         (a32),
    .b         (b32),
    .out_valid (ov32),
    .out_ready (ordy32),
    .result    (res32)
`ifdef GCD_CYCLES_EN
    ,
    .cycles    (cyc32)
`endif
  );

  gcd_stein #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v8),
    .in_ready  (rdy8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .result    (res8)
`ifdef GCD_CYCLES_EN
    ,
    .cycles    (cyc8)
`endif
  );

`ifndef GCD_CYCLES_EN
  assign cyc32 = 16'd0;
  assign cyc8  = 16'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a pair, wait for acceptance, then wait (bounded) for out_valid without consuming.
  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_v,
                       output logic [31:0] res, output logic [15:0] cyc, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    a32 = ta; b32 = tb_v; v32 = 1'b1;
    while (!rdy32 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    v32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 200) begin @(negedge clk); lat++; end
    if (!ov32) begin
      n_vec++; n_err++;
      $display("FAIL run32_timeout a=%0d b=%0d: out_valid never rose", ta, tb_v);
    end
    res = res32; cyc = cyc32;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                      output logic [7:0] res, output logic [15:0] cyc);
    int n;
    n = 0;
    @(negedge clk);
    a8 = ta; b8 = tb_v; v8 = 1'b1;
    while (!rdy8 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    v8 = 1'b0;
    n = 1;
    while (!ov8 && n < 200) begin @(negedge clk); n++; end
    if (!ov8) begin
      n_vec++; n_err++;
      $display("FAIL run8_timeout a=%0d b=%0d: out_valid never rose", ta, tb_v);
    end
    res = res8; cyc = cyc8;
  endtask

  task automatic consume32();
    @(negedge clk); ordy32 = 1'b1;
    @(negedge clk); ordy32 = 1'b0;
  endtask

  task automatic consume8();
    @(negedge clk); ordy8 = 1'b1;
    @(negedge clk); ordy8 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rdy32 !== 1'b1 || ov32 !== 1'b0 || res32 !== 32'd0) begin
      n_err++;
      $display("FAIL reset32: rdy=%b ov=%b res=%0d, want rdy=1 ov=0 res=0", rdy32, ov32, res32);
    end
    n_vec++;
    if (rdy8 !== 1'b1 || ov8 !== 1'b0 || res8 !== 8'd0) begin
      n_err++;
      $display("FAIL reset8: rdy=%b ov=%b res=%0d, want rdy=1 ov=0 res=0", rdy8, ov8, res8);
    end
`ifdef GCD_CYCLES_EN
    n_vec++;
    if (cyc32 !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cycles: got %0d want 0", cyc32);
    end
`endif
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [15:0] c; int lat;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic [15:0] vc [4];
    va = '{32'd161, 32'd48, 32'hFFFF_FFFF, 32'h8000_0000};
    vb = '{32'd14,  32'd18, 32'hFFFF_FFFF, 32'h8000_0000};
    vr = '{32'd7,   32'd6,  32'hFFFF_FFFF, 32'h8000_0000};
    vc = '{16'd10,  16'd8,  16'd2,         16'd33};
    for (int i = 0; i < 4; i++) begin
      run32(va[i], vb[i], r, c, lat);
      n_vec++;
      if (r !== vr[i]) begin
        n_err++;
        $display("FAIL basic_result a=%0d b=%0d: got %0d want %0d", va[i], vb[i], r, vr[i]);
      end
`ifdef GCD_CYCLES_EN
      n_vec++;
      if (c !== vc[i]) begin
        n_err++;
        $display("FAIL basic_cycles a=%0d b=%0d: got %0d want %0d", va[i], vb[i], c, vc[i]);
      end
`endif
      consume32();
    end
  endtask

  task automatic test_zero();
    logic [31:0] r; logic [15:0] c; int lat;
    run32(32'd0, 32'd25, r, c, lat);
    n_vec++;
    if (r !== 32'd25 || lat != 1) begin
      n_err++;
      $display("FAIL zero_0_25: result=%0d latency=%0d, want result=25 latency=1", r, lat);
    end
`ifdef GCD_CYCLES_EN
    n_vec++;
    if (c !== 16'd0) begin
      n_err++;
      $display("FAIL zero_cycles: got %0d want 0", c);
    end
`endif
    consume32();
    run32(32'd0, 32'd0, r, c, lat);
    n_vec++;
    if (r !== 32'd0) begin
      n_err++;
      $display("FAIL zero_0_0: got %0d want 0", r);
    end
    consume32();
    run32(32'd40, 32'd0, r, c, lat);
    n_vec++;
    if (r !== 32'd40 || lat != 1) begin
      n_err++;
      $display("FAIL zero_40_0: result=%0d latency=%0d, want result=40 latency=1", r, lat);
    end
    consume32();
  endtask

  task automatic test_width8();
    logic [7:0] r; logic [15:0] c;
    run8(8'd255, 8'd255, r, c);
    n_vec++;
    if (r !== 8'd255) begin
      n_err++;
      $display("FAIL w8_255_255: got %0d want 255", r);
    end
`ifdef GCD_CYCLES_EN
    n_vec++;
    if (c !== 16'd2) begin
      n_err++;
      $display("FAIL w8_255_cycles: got %0d want 2", c);
    end
`endif
    consume8();
    run8(8'd128, 8'd64, r, c);
    n_vec++;
    if (r !== 8'd64) begin
      n_err++;
      $display("FAIL w8_128_64: got %0d want 64", r);
    end
`ifdef GCD_CYCLES_EN
    n_vec++;
    if (c !== 16'd9) begin
      n_err++;
      $display("FAIL w8_128_cycles: got %0d want 9", c);
    end
`endif
    consume8();
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic [15:0] c; int lat;
    run32(32'd48, 32'd18, r, c, lat);
    a32 = 32'd3; b32 = 32'd9; v32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (ov32 !== 1'b1 || res32 !== 32'd6 || rdy32 !== 1'b0 || cyc32 !== c) begin
        n_err++;
        $display("FAIL stall_cycle%0d: ov=%b res=%0d rdy=%b cyc=%0d, want ov=1 res=6 rdy=0 cyc=%0d",
                 i, ov32, res32, rdy32, cyc32, c);
      end
    end
    v32 = 1'b0;
    consume32();
    n_vec++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || res32 !== 32'd6) begin
      n_err++;
      $display("FAIL post_handshake: ov=%b rdy=%b res=%0d, want ov=0 rdy=1 res=6", ov32, rdy32, res32);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] r; logic [15:0] c; int lat;
    @(negedge clk);
    a32 = 32'd161; b32 = 32'd14; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || res32 !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: ov=%b rdy=%b res=%0d, want ov=0 rdy=1 res=0", ov32, rdy32, res32);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++;
      if (ov32 !== 1'b0 || rdy32 !== 1'b1) begin
        n_err++;
        $display("FAIL after_reset%0d: ov=%b rdy=%b, want ov=0 rdy=1", i, ov32, rdy32);
      end
    end
    run32(32'd12, 32'd8, r, c, lat);
    n_vec++;
    if (r !== 32'd4) begin
      n_err++;
      $display("FAIL reset_next_pair: got %0d want 4", r);
    end
`ifdef GCD_CYCLES_EN
    n_vec++;
    if (c !== 16'd7) begin
      n_err++;
      $display("FAIL reset_next_cycles: got %0d want 7", c);
    end
`endif
    consume32();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [15:0] c; int lat;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    va = '{32'd1071, 32'd17, 32'd1000000};
    vb = '{32'd462,  32'd5,  32'd750000};
    vr = '{32'd21,   32'd1,  32'd250000};
    for (int i = 0; i < 3; i++) begin
      run32(va[i], vb[i], r, c, lat);
      n_vec++;
      if (r !== vr[i]) begin
        n_err++;
        $display("FAIL b2b a=%0d b=%0d: got %0d want %0d", va[i], vb[i], r, vr[i]);
      end
      consume32();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    v32 = 1'b0; ordy32 = 1'b0; a32 = '0; b32 = '0;
    v8  = 1'b0; ordy8  = 1'b0; a8  = '0; b8  = '0;
    test_reset();
    test_basic();
    test_zero();
    test_width8();
    test_backpressure();
    test_reset_midcalc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
